// File: rtl/fetch_buffer.sv
// fetch_buffer: in-order circular queue between the 3-wide fetch stage and
// decode. It accepts up to three packets per cycle, compacted by valid bit,
// and presents the three oldest entries to decode, which takes 0..3 of them.
// Optional build macro FB_ORDER_CHECK_EN adds a sticky PC-order violation flag.
// Without the macro, order_err is tied low.

package fetch_buffer_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] PC;
        logic [31:0] inst;
    } IF_ID_PACKET;
endpackage

module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              squash,
    input  IF_ID_PACKET       in_packet_0,
    input  IF_ID_PACKET       in_packet_1,
    input  IF_ID_PACKET       in_packet_2,
    input  logic [1:0]        dec_take,
    output IF_ID_PACKET       out_packet_0,
    output IF_ID_PACKET       out_packet_1,
    output IF_ID_PACKET       out_packet_2,
    output logic [1:0]        out_cnt,
    output logic              if_stall,
    output logic [CNT_W-1:0]  count,
    output logic              order_err
);

    localparam int               PTR_W   = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [DEPTH-1:0] r_vld;
    logic [31:0]      r_pc   [DEPTH];
    logic [31:0]      r_inst [DEPTH];

    IF_ID_PACKET      w_in     [3];
    IF_ID_PACKET      w_out    [3];
    logic [1:0]       w_off    [3];
    logic [PTR_W-1:0] w_wr_idx [3];
    logic [PTR_W-1:0] w_rd_idx [3];
    logic [1:0]       w_enq_cnt;
    logic             w_accept;
    logic [CNT_W-1:0] w_take;
    logic [CNT_W-1:0] w_deq;
    logic [CNT_W-1:0] w_enq;

    assign w_in[0] = in_packet_0;
    assign w_in[1] = in_packet_1;
    assign w_in[2] = in_packet_2;

    // Stall only on registered occupancy: a full fetch group must fit without
    // counting on this cycle's dequeue.
    assign if_stall = (DEPTH_C - r_count) < CNT_W'(3);
    assign w_accept = !if_stall && !squash;
    assign count    = r_count;
    assign out_cnt  = (r_count >= CNT_W'(3)) ? 2'd3 : r_count[1:0];

    // Compaction offsets: each valid input lands after the valid ones before it.
    always_comb begin
        w_enq_cnt = 2'd0;
        for (int k = 0; k < 3; k++) begin
            w_off[k]    = w_enq_cnt;
            w_wr_idx[k] = r_tail + PTR_W'(w_enq_cnt);
            w_rd_idx[k] = r_head + PTR_W'(k);
            if (w_in[k].valid) begin
                w_enq_cnt = w_enq_cnt + 2'd1;
            end
        end
    end

    // Dequeue clamped to occupancy; enqueue count zero when not accepting.
    always_comb begin
        w_take = CNT_W'(dec_take);
        w_deq  = (w_take > r_count) ? r_count : w_take;
        w_enq  = w_accept ? CNT_W'(w_enq_cnt) : '0;
    end

    // Control state: pointers, occupancy and per-entry valid bits.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_vld   <= '0;
        end else if (squash) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_vld   <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_deq);
            r_tail  <= r_tail + PTR_W'(w_enq);
            r_count <= r_count + w_enq - w_deq;
            // Retired and newly written slots never overlap: enqueue needs
            // three free slots, dequeue only touches occupied ones.
            for (int k = 0; k < 3; k++) begin
                if (CNT_W'(k) < w_deq) begin
                    r_vld[w_rd_idx[k]] <= 1'b0;
                end
            end
            for (int k = 0; k < 3; k++) begin
                if (w_accept && w_in[k].valid) begin
                    r_vld[w_wr_idx[k]] <= 1'b1;
                end
            end
        end
    end

    // Entry payload: written on accept, no reset needed (guarded by r_vld/out_cnt).
    always_ff @(posedge clock) begin
        for (int k = 0; k < 3; k++) begin
            if (w_accept && w_in[k].valid) begin
                r_pc[w_wr_idx[k]]   <= w_in[k].PC;
                r_inst[w_wr_idx[k]] <= w_in[k].inst;
            end
        end
    end

    // Output slots: oldest three entries, zeroed beyond out_cnt.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            w_out[k] = '0;
            if (2'(k) < out_cnt) begin
                w_out[k].valid = r_vld[w_rd_idx[k]];
                w_out[k].PC    = r_pc[w_rd_idx[k]];
                w_out[k].inst  = r_inst[w_rd_idx[k]];
            end
        end
    end

    assign out_packet_0 = w_out[0];
    assign out_packet_1 = w_out[1];
    assign out_packet_2 = w_out[2];

`ifdef FB_ORDER_CHECK_EN
    logic [31:0] r_last_pc;
    logic        r_order_err;
    logic        w_order_bad;
    logic [31:0] w_last_next;

    // Walk valid inputs in slot order; the first is compared against the
    // youngest buffered PC when the queue is non-empty.
    always_comb begin
        logic        have_prev;
        logic [31:0] prev_pc;
        have_prev   = (r_count != '0);
        prev_pc     = r_last_pc;
        w_order_bad = 1'b0;
        w_last_next = r_last_pc;
        for (int k = 0; k < 3; k++) begin
            if (w_in[k].valid) begin
                if (have_prev && (w_in[k].PC <= prev_pc)) begin
                    w_order_bad = 1'b1;
                end
                have_prev   = 1'b1;
                prev_pc     = w_in[k].PC;
                w_last_next = w_in[k].PC;
            end
        end
    end

    // Sticky error flag and youngest-enqueued PC tracker.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_order_err <= 1'b0;
            r_last_pc   <= '0;
        end else if (squash) begin
            r_order_err <= 1'b0;
            r_last_pc   <= '0;
        end else if (w_accept && (w_enq_cnt != 2'd0)) begin
            r_order_err <= r_order_err | w_order_bad;
            r_last_pc   <= w_last_next;
        end
    end

    assign order_err = r_order_err;
`else
    assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed self-checking bench for fetch_buffer (DEPTH=8).
module tb_fetch_buffer;
    import fetch_buffer_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clock;
    logic             reset;
    logic             squash;
    IF_ID_PACKET      in_packet_0, in_packet_1, in_packet_2;
    logic [1:0]       dec_take;
    IF_ID_PACKET      out_packet_0, out_packet_1, out_packet_2;
    logic [1:0]       out_cnt;
    logic             if_stall;
    logic [CNT_W-1:0] count;
    logic             order_err;

    int checks = 0;
    int errors = 0;

    fetch_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .squash(squash),
        .in_packet_0(in_packet_0), .in_packet_1(in_packet_1), .in_packet_2(in_packet_2),
        .dec_take(dec_take),
        .out_packet_0(out_packet_0), .out_packet_1(out_packet_1), .out_packet_2(out_packet_2),
        .out_cnt(out_cnt), .if_stall(if_stall), .count(count), .order_err(order_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic IF_ID_PACKET mk(input logic v, input logic [31:0] pc);
        IF_ID_PACKET p;
        p = '0;
        if (v) begin
            p.valid = 1'b1;
            p.PC    = pc;
            p.inst  = ~pc;
        end
        return p;
    endfunction

    task automatic drive(input logic v0, input logic [31:0] pc0,
                         input logic v1, input logic [31:0] pc1,
                         input logic v2, input logic [31:0] pc2,
                         input logic [1:0] take, input logic sq);
        in_packet_0 = mk(v0, pc0);
        in_packet_1 = mk(v1, pc1);
        in_packet_2 = mk(v2, pc2);
        dec_take    = take;
        squash      = sq;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0, 2'd0, 0);
        reset = 1'b0;
        #2;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (out_packet_0.valid !== 1'b0) begin errors++; $display("FAIL reset_out0_valid got %0b want 0", out_packet_0.valid); end
        checks++; if (order_err !== 1'b0) begin errors++; $display("FAIL reset_order_err got %0b want 0", order_err); end
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (count !== 4'd0 || out_cnt !== 2'd0 || if_stall !== 1'b0) begin
                errors++;
                $display("FAIL idle_cycle%0d got count=%0d out_cnt=%0d stall=%0b want 0/0/0", i, count, out_cnt, if_stall);
            end
        end
    endtask

    task automatic test_fill_stall();
        drive(1, 32'h00, 1, 32'h04, 1, 32'h08, 2'd0, 0);
        step();
        checks++; if (count !== 4'd3 || if_stall !== 1'b0) begin errors++; $display("FAIL fill1 got count=%0d stall=%0b want 3/0", count, if_stall); end
        drive(1, 32'h0C, 1, 32'h10, 1, 32'h14, 2'd0, 0);
        step();
        checks++; if (count !== 4'd6 || if_stall !== 1'b1) begin errors++; $display("FAIL fill2 got count=%0d stall=%0b want 6/1", count, if_stall); end
        drive(1, 32'h18, 1, 32'h1C, 1, 32'h20, 2'd0, 0);
        step();
        checks++; if (count !== 4'd6) begin errors++; $display("FAIL fill_drop got count=%0d want 6", count); end
        checks++; if (out_packet_0.PC !== 32'h00 || out_packet_0.valid !== 1'b1) begin errors++; $display("FAIL fill_out0 got pc=%h v=%0b want 00/1", out_packet_0.PC, out_packet_0.valid); end
        checks++; if (out_cnt !== 2'd3 || out_packet_2.PC !== 32'h08 || out_packet_2.inst !== ~32'h08) begin errors++; $display("FAIL fill_out2 got cnt=%0d pc=%h inst=%h want 3/08/%h", out_cnt, out_packet_2.PC, out_packet_2.inst, ~32'h08); end
    endtask

    task automatic test_compact_wrap();
        // Drain six entries: head moves 0 -> 3 -> 6
        drive(0, 0, 0, 0, 0, 0, 2'd3, 0);
        step();
        checks++; if (count !== 4'd3 || out_packet_0.PC !== 32'h0C || out_packet_2.PC !== 32'h14) begin errors++; $display("FAIL drain1 got count=%0d pc0=%h pc2=%h want 3/0C/14", count, out_packet_0.PC, out_packet_2.PC); end
        step();
        checks++; if (count !== 4'd0 || out_cnt !== 2'd0) begin errors++; $display("FAIL drain2 got count=%0d cnt=%0d want 0/0", count, out_cnt); end
        drive(1, 32'h40, 0, 32'h44, 1, 32'h48, 2'd0, 0);
        step();
        checks++; if (count !== 4'd2 || out_cnt !== 2'd2) begin errors++; $display("FAIL compact_cnt got count=%0d cnt=%0d want 2/2", count, out_cnt); end
        checks++; if (out_packet_0.PC !== 32'h40 || out_packet_1.PC !== 32'h48 || out_packet_2.valid !== 1'b0 || out_packet_2.PC !== 32'h0) begin errors++; $display("FAIL compact_pcs got %h/%h v2=%0b pc2=%h want 40/48/0/0", out_packet_0.PC, out_packet_1.PC, out_packet_2.valid, out_packet_2.PC); end
        drive(0, 0, 0, 0, 0, 0, 2'd3, 0);
        step();
        checks++; if (count !== 4'd0 || out_cnt !== 2'd0) begin errors++; $display("FAIL clamp_take got count=%0d cnt=%0d want 0/0", count, out_cnt); end
    endtask

    task automatic test_back_to_back();
        drive(1, 32'h50, 1, 32'h54, 1, 32'h58, 2'd0, 0);
        step();
        drive(1, 32'h5C, 0, 0, 0, 0, 2'd0, 0);
        step();
        checks++; if (count !== 4'd4 || out_packet_0.PC !== 32'h50) begin errors++; $display("FAIL b2b_pre got count=%0d pc0=%h want 4/50", count, out_packet_0.PC); end
        drive(1, 32'h60, 1, 32'h64, 1, 32'h68, 2'd3, 0);
        step();
        checks++; if (count !== 4'd4 || out_cnt !== 2'd3) begin errors++; $display("FAIL b2b_count got count=%0d cnt=%0d want 4/3", count, out_cnt); end
        checks++; if (out_packet_0.PC !== 32'h5C || out_packet_1.PC !== 32'h60 || out_packet_2.PC !== 32'h64) begin errors++; $display("FAIL b2b_order got %h/%h/%h want 5C/60/64", out_packet_0.PC, out_packet_1.PC, out_packet_2.PC); end
    endtask

    task automatic test_squash();
        drive(1, 32'h6C, 0, 0, 0, 0, 2'd0, 0);
        step();
        checks++; if (count !== 4'd5) begin errors++; $display("FAIL squash_pre got count=%0d want 5", count); end
        drive(1, 32'h70, 1, 32'h74, 1, 32'h78, 2'd2, 1);
        step();
        checks++; if (count !== 4'd0 || out_cnt !== 2'd0 || if_stall !== 1'b0 || out_packet_0.valid !== 1'b0) begin errors++; $display("FAIL squash_clear got count=%0d cnt=%0d stall=%0b v0=%0b want 0/0/0/0", count, out_cnt, if_stall, out_packet_0.valid); end
        drive(1, 32'h100, 0, 0, 0, 0, 2'd0, 0);
        #1;
        checks++; if (out_cnt !== 2'd0 || out_packet_0.valid !== 1'b0) begin errors++; $display("FAIL no_bypass got cnt=%0d v0=%0b want 0/0", out_cnt, out_packet_0.valid); end
        step();
        checks++; if (out_packet_0.PC !== 32'h100 || out_packet_0.valid !== 1'b1 || count !== 4'd1) begin errors++; $display("FAIL post_squash got pc=%h v=%0b count=%0d want 100/1/1", out_packet_0.PC, out_packet_0.valid, count); end
    endtask

    task automatic test_async_reset();
        drive(1, 32'h200, 1, 32'h204, 0, 0, 2'd0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 2'd0, 0);
        #2;
        reset = 1'b0;
        #1;
        checks++; if (count !== 4'd0 || out_cnt !== 2'd0 || out_packet_0.valid !== 1'b0) begin errors++; $display("FAIL async_reset got count=%0d cnt=%0d v0=%0b want 0/0/0", count, out_cnt, out_packet_0.valid); end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_order_check();
        logic exp;
`ifdef FB_ORDER_CHECK_EN
        exp = 1'b1;
`else
        exp = 1'b0;
`endif
        drive(1, 32'h10, 1, 32'h0C, 1, 32'h14, 2'd0, 0);
        step();
        checks++; if (order_err !== exp) begin errors++; $display("FAIL order_set got %0b want %0b", order_err, exp); end
        drive(0, 0, 0, 0, 0, 0, 2'd0, 0);
        step();
        checks++; if (order_err !== exp) begin errors++; $display("FAIL order_hold got %0b want %0b", order_err, exp); end
        drive(0, 0, 0, 0, 0, 0, 2'd0, 1);
        step();
        checks++; if (order_err !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL order_squash got err=%0b count=%0d want 0/0", order_err, count); end
        // Ascending within a group but not above the buffered youngest entry.
        drive(1, 32'h20, 0, 0, 0, 0, 2'd0, 0);
        step();
        checks++; if (order_err !== 1'b0) begin errors++; $display("FAIL order_ok got %0b want 0", order_err); end
        drive(1, 32'h20, 1, 32'h24, 0, 0, 2'd0, 0);
        step();
        checks++; if (order_err !== exp) begin errors++; $display("FAIL order_vs_last got %0b want %0b", order_err, exp); end
    endtask

    initial begin
        test_reset();
        test_fill_stall();
        test_compact_wrap();
        test_back_to_back();
        test_squash();
        test_async_reset();
        test_order_check();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
In-order instruction fetch buffer between the 3-wide fetch stage and decode.
- Each cycle it accepts up to three IF_ID_PACKETs, already PC-sorted upstream, into a circular queue.
- It presents up to three oldest entries to decode, which consumes a variable count per cycle.
- It backpressures fetch when the queue cannot absorb a full fetch group, and empties on squash (branch mispredict / exception).

Parameters:
DEPTH, 8, queue entries; power of two, >= 4
CNT_W, $clog2(DEPTH)+1, width of occupancy counter

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
squash  input  1  flush all entries, synchronous
in_packet_0  input  IF_ID_PACKET  oldest fetched slot
in_packet_1  input  IF_ID_PACKET  middle fetched slot
in_packet_2  input  IF_ID_PACKET  youngest fetched slot
dec_take  input  2  number of entries decode consumes this cycle, 0..3
out_packet_0  output  IF_ID_PACKET  oldest buffered entry
out_packet_1  output  IF_ID_PACKET  second oldest
out_packet_2  output  IF_ID_PACKET  third oldest
out_cnt  output  2  number of valid out_packet slots, min(count,3)
if_stall  output  1  fetch must hold; inputs ignored this cycle
count  output  CNT_W  current occupancy
order_err  output  1  sticky PC-order violation flag (see Optional Feature)

Behaviour:
State
- Registers: head ptr, tail ptr (log2(DEPTH) bits, wrap modulo DEPTH), count, entry array.
- All update on rising clock.
- Reset (reset==0, async): head=tail=0, count=0, order_err=0, all entry valid bits 0.
- Consequently at reset: out_cnt=0, all out_packet_n.valid=0, if_stall=0.

Stall
- if_stall = (DEPTH - count) < 3, from registered count only.
- No same-cycle dequeue credit.

Enqueue (if_stall==0, squash==0)
- Only packets with .valid=1 are written, compacted in slot order 0,1,2 starting at tail.
- tail += number of valid inputs (0..3).
- Non-contiguous valid bits (e.g. 1,0,1) are legal and compact to two consecutive entries.
- When if_stall==1, all inputs are dropped; fetch is responsible for holding them.

Dequeue
- deq = min(dec_take, count); head += deq.
- dec_take > count is not an error; it is clamped.

Occupancy and outputs
- count_next = count + enq - deq.
- Simultaneous enqueue and dequeue in the same cycle is permitted.
- out_packet_k = entry[(head+k) mod DEPTH] for k < out_cnt; otherwise all fields zero with .valid=0.
- Outputs are combinational from registered state.
- Latency: a packet enqueued in cycle t appears at the outputs in cycle t+1 at the earliest. No input-to-output bypass.

Squash
- Highest priority. Next cycle: head=tail=0, count=0.
- Same-cycle inputs and dec_take are ignored.
- order_err clears.

Boundaries
- Wrap-around: pointer arithmetic is modulo DEPTH, and output slot indexing wraps likewise.
- count never exceeds DEPTH, because if_stall guarantees 3 free entries before any enqueue.
- Reset asserted mid-operation discards everything immediately, without waiting for a clock edge.

Optional Feature:
Macro FB_ORDER_CHECK_EN.
- Defined: on each accepted enqueue, order_err is set and held (until squash or reset) if either condition holds:
  - the valid input PCs are not strictly ascending in slot order, or
  - the first valid input PC is <= the PC of the most recently enqueued entry while count>0.
- Defined: comparison is unsigned on the full PC field.
- Undefined: no comparison logic is built and order_err is tied 0. The port is present in both builds.

Test Plan:
1. Reset then idle: release reset, all inputs invalid, dec_take=0 for 5 cycles -> count=0, out_cnt=0, if_stall=0 throughout.
2. Fill to stall (DEPTH=8, dec_take=0): enqueue 3 valid packets/cycle with PCs 0x00..0x20 step 4 -> count goes 3,6; if_stall=1 when count=6. Third group dropped, count stays 6, out_packet_0.PC=0x00.
3. Compaction and wrap: with head=6, enqueue valid=1,0,1 (PCs 0x40,-,0x48) -> entries 6 and 7 written. With dec_take=3 the next cycle, out_packet_0/1 PCs are 0x40/0x48, out_cnt=2, and head wraps to 0.
4. Simultaneous enqueue/dequeue: count=4, enqueue 3, dec_take=3 -> count=4 next cycle. Oldest three retired in order and the newly enqueued PCs follow the remaining entry.
5. Squash mid-stream: count=5, squash=1 with 3 valid inputs and dec_take=2 -> next cycle count=0, out_cnt=0, if_stall=0. Subsequent enqueue of PC 0x100 appears at out_packet_0 one cycle later.
6. FB_ORDER_CHECK_EN defined: enqueue PCs 0x10,0x0C,0x14 -> order_err=1 next cycle and stays 1 until squash. Undefined build, same stimulus -> order_err=0.
